// File: rtl/mem_stream_reader_pkg.sv
// Shared definitions for the memory stream reader and the memory block it reads.
package mem_stream_reader_pkg;

    // Default widths, kept in step with the memory read port.
    localparam int MSR_ADDR_W     = 18;
    localparam int MSR_DATA_W     = 8;
    localparam int MSR_LEN_W      = 18;
    localparam int MSR_FIFO_DEPTH = 4;

    // Transfer sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } msr_state_t;

endpackage

// File: rtl/mem_stream_reader_sync_fifo.sv
// Small synchronous FIFO holding read words between the memory and the stream port.
// DEPTH must be a power of two so the pointers wrap on their own.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_push_data,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage: cleared on reset so the head reads zero until the first push.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_stream_reader.sv
// Reads a run of consecutive words from a 1-cycle-latency memory and emits them
// as a valid/ready stream with a last flag.
//
// Stream handshake: a beat transfers on a rising edge where m_valid && m_ready.
// Once m_valid is high it stays high, with m_data and m_last unchanged, until
// the beat transfers; m_valid never depends on m_ready.
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int ADDR_W     = MSR_ADDR_W,
    parameter int DATA_W     = MSR_DATA_W,
    parameter int LEN_W      = MSR_LEN_W,
    parameter int FIFO_DEPTH = MSR_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              mem_r_en,
    output logic [ADDR_W-1:0] mem_r_add,
    input  logic [DATA_W-1:0] mem_r_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic [1:0]        o_dbg_state
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    msr_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_issue_cnt;
    logic [LEN_W-1:0]  r_beat_cnt;
    logic              r_inflight;

    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic              w_credit_ok;
    logic              w_issue;
    logic              w_pop;

    // Credit: words already buffered plus the one still coming back from memory
    // must leave room, so every returning word has a free FIFO slot.
    assign w_credit_ok = ({1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight})
                         < (CNT_W+1)'(FIFO_DEPTH);
    assign w_issue     = (r_state == ST_ISSUE) && w_credit_ok && !w_full;
    assign w_pop       = !w_empty && m_ready;

    assign mem_r_en    = w_issue;
    assign mem_r_add   = r_addr;
    assign m_valid     = !w_empty;
    assign m_data      = w_head;
    assign m_last      = !w_empty && (r_beat_cnt == LEN_W'(1));
    assign busy        = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    assign done        = (r_state == ST_DONE);
    assign o_dbg_state = r_state;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_push      (r_inflight),
        .i_push_data (mem_r_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    // Sequencer: command capture, read issue with credit, drain and completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_issue_cnt <= '0;
            r_beat_cnt  <= '0;
            r_inflight  <= 1'b0;
        end else begin
            // Memory data returns one cycle after the read; it is pushed then.
            r_inflight <= w_issue;

            if (w_pop && (r_beat_cnt != '0)) begin
                r_beat_cnt <= r_beat_cnt - LEN_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr      <= base_addr;
                        r_issue_cnt <= length;
                        r_beat_cnt  <= length;
                        r_state     <= (length == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_issue) begin
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_issue_cnt <= r_issue_cnt - LEN_W'(1);
                        if (r_issue_cnt == LEN_W'(1)) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave on the final handshake so done lands on the next cycle.
                    if ((r_beat_cnt == '0) || ((r_beat_cnt == LEN_W'(1)) && w_pop)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_stream_reader.md
Name: mem_stream_reader

Overview:
- Read-side sequencer for the team's synchronous single-port-read memory: r_en/r_add in, r_data registered one cycle later.
- On a start command it reads `length` consecutive words from `base_addr`.
- The words leave as a valid/ready stream, with a last flag, to the downstream feature/compare pipeline.
- Absorbs the memory's 1-cycle read latency and downstream backpressure with a small internal FIFO, so no word is lost or duplicated.

Parameters:
ADDR_W, 18, memory address width (matches memory read address).
DATA_W, 8, memory read-data / stream data width.
LEN_W, 18, width of the transfer length field.
FIFO_DEPTH, 4, internal buffer entries (power of two, >=4).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle command strobe; sampled only when busy=0
base_addr  input  ADDR_W  first address, captured with start
length  input  LEN_W  number of words, captured with start; 0 is legal
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the transfer completes
mem_r_en  output  1  memory read enable
mem_r_add  output  ADDR_W  memory read address
mem_r_data  input  DATA_W  memory read data, valid the cycle after mem_r_en
m_valid  output  1  stream data valid
m_data  output  DATA_W  stream data
m_last  output  1  qualifies the final word of the transfer (only while m_valid)
m_ready  input  1  downstream accept

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: busy=0, done=0, mem_r_en=0, mem_r_add=0, m_valid=0, m_data=0, m_last=0.
- Reset clears the FIFO, counters and FSM.
- Reset mid-transfer aborts it: no done pulse, and a later start begins cleanly.

FSM states and transitions:
- IDLE -> ISSUE on start with length!=0. Capture base_addr into the address counter and length into both the issue and beat counters.
- IDLE -> DONE on start with length==0. No memory read, no stream beat.
- ISSUE: each cycle, assert mem_r_en with mem_r_add = address counter when (fifo_occupancy + inflight) < FIFO_DEPTH.
  - inflight is a 1-bit flag: a read was issued last cycle.
  - occupancy is the current registered count; there is no pop lookahead.
  - On each issue, increment the address and decrement the issue counter.
  - After the last issue, go to DRAIN.
- DRAIN: wait until the beat counter reaches 0, i.e. the final beat is handshaken, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- start while busy=1 is ignored.

Data path and timing:
- mem_r_data is pushed into the FIFO in the cycle after each issue (inflight=1).
- m_valid = FIFO non-empty; m_data = FIFO head. Pop on m_valid && m_ready.
- m_data and m_last are held stable while m_valid && !m_ready.
- m_last = m_valid && (beat counter == 1).
- Latency: start high in cycle 0 -> mem_r_en in cycle 1 -> push at end of cycle 2 -> first m_valid in cycle 3.
- With m_ready held high, one beat per cycle after the first.
- done is asserted in the cycle after the final handshake.

Boundaries:
- Address wrap: the address increments modulo 2^ADDR_W.
- FIFO full: no issue. The credit rule guarantees a push never hits a full FIFO; the bench asserts this.
- Simultaneous push and pop: occupancy is unchanged.
- busy=1 from the cycle after start through the cycle before done; busy=0 in the done cycle.

Decomposition:
- Shared package: FSM state enum (IDLE, ISSUE, DRAIN, DONE) and default ADDR_W/DATA_W constants shared with the memory block.
- One natural sub-module: sync_fifo (parameterised DATA_W/FIFO_DEPTH; push, pop, full, empty, count).
- Everything else (FSM, counters, credit logic) lives in the top.

Test Plan:
- Contiguous transfer: mem[10..13]=A0..A3; start with base=10, length=4, m_ready=1 -> beats A0..A3 in cycles 3..6, m_last only in cycle 6, done in cycle 7, exactly 4 mem_r_en pulses.
- Backpressure: length=8 with m_ready toggling 1,0,0,1,... -> all 8 words delivered in order, none duplicated; m_data stable while stalled; FIFO never overflows; mem_r_en stalls once occupancy+inflight=4.
- Zero length: start with length=0 -> no mem_r_en, no m_valid, done one cycle after start.
- Address wrap: base=2^18-2, length=4 -> reads addresses 3FFFE, 3FFFF, 0, 1 in that order.
- Busy and abort: start pulsed again during a transfer -> ignored, word count unchanged; rst_n low mid-transfer -> all outputs 0 immediately, no done, next start with length=2 completes normally.
